// File: rtl/crg_job_sched_pkg.sv
// -----------------------------------------------------------------------------
// crg_job_sched_pkg
// Shared types and constants for the CRG job scheduler: CRG configuration
// field types, the job descriptor a requester submits, the scheduler FSM
// state encoding and a descriptor validity helper.
// -----------------------------------------------------------------------------
package crg_job_sched_pkg;

    // Pipeline latency of the CRG from run pulse to its first output beat.
    localparam int CRG_LAT = 28;
    localparam int CNT_W   = 16;

    typedef logic [31:0]      key_t;
    typedef logic [1:0]       width_t;
    typedef logic [CNT_W-1:0] cr_cnt_t;

    typedef enum logic [1:0] {
        MODE_UNIFORM = 2'd0,
        MODE_BINARY  = 2'd1,
        MODE_ARITH   = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_t;

    typedef struct packed {
        logic    party;
        mode_t   mode;
        width_t  width;
        cr_cnt_t cnt_start;
        cr_cnt_t cnt_end;
    } job_desc_t;

    // IDLE is encoded as zero so the debug state reads 0 in reset.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_STREAM = 3'd3,
        ST_RESP   = 3'd4
    } sched_state_t;

    // A count window is usable only if both ends are non-zero and ordered.
    // start>=1 also guarantees end-start+1 cannot wrap.
    function automatic logic desc_valid(input job_desc_t d);
        return (d.cnt_start != '0) && (d.cnt_end != '0) && (d.cnt_end >= d.cnt_start);
    endfunction

endpackage

// File: rtl/crg_job_sched_if.sv
// -----------------------------------------------------------------------------
// crg_job_sched_if
// Descriptor submission bus between N_REQ requesters and the scheduler.
//   req_valid_i : per-requester descriptor valid
//   req_ready_o : per-requester accept, one-hot (at most one bit high)
//   req_desc_i  : per-requester job descriptor
// Handshake: a descriptor transfers on a rising clock edge where both
// req_valid_i[i] and req_ready_o[i] are high. A requester holds valid and its
// descriptor stable until that edge; ready may rise and fall without valid
// changing, and ready never depends on anything but valid and scheduler state.
// -----------------------------------------------------------------------------
interface crg_job_sched_if
    import crg_job_sched_pkg::*;
#(
    parameter int N_REQ = 4
);

    logic [N_REQ-1:0] req_valid_i;
    logic [N_REQ-1:0] req_ready_o;
    job_desc_t        req_desc_i [N_REQ];

    modport master (
        output req_valid_i,
        output req_desc_i,
        input  req_ready_o
    );

    modport slave (
        input  req_valid_i,
        input  req_desc_i,
        output req_ready_o
    );

endinterface

// File: rtl/crg_job_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// crg_job_sched_rr_arbiter
// Combinational round-robin pick: the first asserted request at or after the
// pointer, wrapping modulo N_REQ.
//   req_i     : request vector
//   ptr_i     : highest-priority index for this pick
//   gnt_o     : one-hot grant
//   gnt_idx_o : index of the granted request
//   gnt_vld_o : any request was granted
// -----------------------------------------------------------------------------
module crg_job_sched_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]  gnt_idx_o,
    output logic             gnt_vld_o
);

    logic [ID_W-1:0] idx;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        idx       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = ID_W'((int'(ptr_i) + i) % N_REQ);
            if (!gnt_vld_o && req_i[idx]) begin
                gnt_vld_o  = 1'b1;
                gnt_idx_o  = idx;
                gnt_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/crg_job_sched.sv
// -----------------------------------------------------------------------------
// crg_job_sched
// Job scheduler in front of the correlated random generator. Accepts one job
// descriptor at a time (round-robin over requesters), validates it, programs
// the CRG config/count window, fires a one-cycle run pulse and tags every
// returned beat with the owning requester until the job drains or stalls.
//   clk_i, rst_n_i        : clock, asynchronous active-low reset
//   key_i / crg_key_o     : global key, passed straight through
//   req_if (slave)        : descriptor handshake from requesters
//   crg_*_o               : CRG config held from LOAD until the next good LOAD
//   crg_run_o             : one-cycle run pulse
//   crg_dvld_i            : CRG output beat valid
//   beat_id_o/beat_last_o : owner and last-beat flag of the current beat
//   done_o/err_o          : one-cycle completion / error pulse, resp_id_o owner
//   busy_o                : FSM not in IDLE
//   dbg_state_o           : current FSM state
// -----------------------------------------------------------------------------
module crg_job_sched
    import crg_job_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ),
    parameter int WDOG  = CRG_LAT + 8
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  key_t            key_i,
    crg_job_sched_if.slave  req_if,
    output key_t            crg_key_o,
    output logic            crg_party_o,
    output mode_t           crg_mode_o,
    output width_t          crg_width_o,
    output cr_cnt_t         crg_cnt_start_o,
    output cr_cnt_t         crg_cnt_end_o,
    output logic            crg_run_o,
    input  logic            crg_dvld_i,
    output logic [ID_W-1:0] beat_id_o,
    output logic            beat_last_o,
    output logic            done_o,
    output logic            err_o,
    output logic [ID_W-1:0] resp_id_o,
    output logic            busy_o,
    output sched_state_t    dbg_state_o
);

    localparam int WD_W = $clog2(WDOG + 1);

    sched_state_t    state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] id_q, id_d;
    job_desc_t       desc_q, desc_d;
    job_desc_t       cfg_q, cfg_d;
    cr_cnt_t         beats_q, beats_d;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            resp_err_q, resp_err_d;

    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_idx;
    logic             gnt_vld;
    logic [N_REQ-1:0] ready;

    crg_job_sched_rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req_i     (req_if.req_valid_i),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            id_q       <= '0;
            desc_q     <= '0;
            cfg_q      <= '0;
            beats_q    <= '0;
            wdog_q     <= '0;
            resp_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            id_q       <= id_d;
            desc_q     <= desc_d;
            cfg_q      <= cfg_d;
            beats_q    <= beats_d;
            wdog_q     <= wdog_d;
            resp_err_q <= resp_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        desc_d     = desc_q;
        cfg_d      = cfg_q;
        beats_d    = beats_q;
        wdog_d     = wdog_q;
        resp_err_d = resp_err_q;
        ready      = '0;
        case (state_q)
            ST_IDLE: begin
                // The grant only selects a valid requester, so ready here
                // always completes the handshake on this edge.
                if (gnt_vld) begin
                    ready   = gnt;
                    id_d    = gnt_idx;
                    desc_d  = req_if.req_desc_i[gnt_idx];
                    ptr_d   = ID_W'((int'(gnt_idx) + 1) % N_REQ);
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (desc_valid(desc_q)) begin
                    cfg_d   = desc_q;
                    beats_d = desc_q.cnt_end - desc_q.cnt_start + cr_cnt_t'(1);
                    state_d = ST_RUN;
                end else begin
                    resp_err_d = 1'b1;
                    state_d    = ST_RESP;
                end
            end
            ST_RUN: begin
                wdog_d     = '0;
                resp_err_d = 1'b0;
                state_d    = ST_STREAM;
            end
            ST_STREAM: begin
                // A beat wins over watchdog expiry in the same cycle.
                if (crg_dvld_i) begin
                    wdog_d  = '0;
                    beats_d = beats_q - cr_cnt_t'(1);
                    if (beats_q == cr_cnt_t'(1)) begin
                        resp_err_d = 1'b0;
                        state_d    = ST_RESP;
                    end
                end else if (wdog_q == WD_W'(WDOG - 1)) begin
                    resp_err_d = 1'b1;
                    state_d    = ST_RESP;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Ready is gated by reset so no accept is advertised while held in reset.
    assign req_if.req_ready_o = rst_n_i ? ready : '0;

    assign crg_key_o       = key_i;
    assign crg_party_o     = cfg_q.party;
    assign crg_mode_o      = cfg_q.mode;
    assign crg_width_o     = cfg_q.width;
    assign crg_cnt_start_o = cfg_q.cnt_start;
    assign crg_cnt_end_o   = cfg_q.cnt_end;
    assign crg_run_o       = (state_q == ST_RUN);
    assign beat_id_o       = id_q;
    assign beat_last_o     = (state_q == ST_STREAM) && crg_dvld_i && (beats_q == cr_cnt_t'(1));
    assign done_o          = (state_q == ST_RESP) && !resp_err_q;
    assign err_o           = (state_q == ST_RESP) && resp_err_q;
    assign resp_id_o       = id_q;
    assign busy_o          = (state_q != ST_IDLE);
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_crg_job_sched.sv
// -----------------------------------------------------------------------------
// tb_crg_job_sched
// Directed bench for crg_job_sched. Inputs are driven just after the falling
// edge and outputs sampled there, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_crg_job_sched;
    import crg_job_sched_pkg::*;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;
    localparam int WDOG  = CRG_LAT + 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    key_t            key;
    logic            crg_dvld;
    key_t            crg_key_o;
    logic            crg_party_o;
    mode_t           crg_mode_o;
    width_t          crg_width_o;
    cr_cnt_t         crg_cnt_start_o;
    cr_cnt_t         crg_cnt_end_o;
    logic            crg_run_o;
    logic [ID_W-1:0] beat_id_o;
    logic            beat_last_o;
    logic            done_o;
    logic            err_o;
    logic [ID_W-1:0] resp_id_o;
    logic            busy_o;
    sched_state_t    dbg_state_o;

    crg_job_sched_if #(.N_REQ(N_REQ)) req_if ();

    crg_job_sched #(.N_REQ(N_REQ), .ID_W(ID_W), .WDOG(WDOG)) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .key_i           (key),
        .req_if          (req_if),
        .crg_key_o       (crg_key_o),
        .crg_party_o     (crg_party_o),
        .crg_mode_o      (crg_mode_o),
        .crg_width_o     (crg_width_o),
        .crg_cnt_start_o (crg_cnt_start_o),
        .crg_cnt_end_o   (crg_cnt_end_o),
        .crg_run_o       (crg_run_o),
        .crg_dvld_i      (crg_dvld),
        .beat_id_o       (beat_id_o),
        .beat_last_o     (beat_last_o),
        .done_o          (done_o),
        .err_o           (err_o),
        .resp_id_o       (resp_id_o),
        .busy_o          (busy_o),
        .dbg_state_o     (dbg_state_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Expected grant order for the round-robin scenario.
    logic [ID_W-1:0] exp_q[$];

    // ---------------- driver tasks ----------------
    function automatic job_desc_t mk_desc(input logic party, input mode_t mode,
                                          input width_t width, input int s, input int e);
        job_desc_t d;
        d.party     = party;
        d.mode      = mode;
        d.width     = width;
        d.cnt_start = cr_cnt_t'(s);
        d.cnt_end   = cr_cnt_t'(e);
        return d;
    endfunction

    task automatic step();
        @(negedge clk);
        crg_dvld = 1'b0;
        #1;
    endtask

    task automatic beat(output logic last, output logic [ID_W-1:0] id);
        @(negedge clk);
        crg_dvld = 1'b1;
        #1;
        last = beat_last_o;
        id   = beat_id_o;
    endtask

    // Presents a descriptor and waits for the accept. Returns the number of
    // cycles waited (-1 on timeout); on return the bench sits in the LOAD cycle.
    task automatic send(input int id, input job_desc_t d, output int wait_cyc);
        req_if.req_desc_i[id]  = d;
        req_if.req_valid_i[id] = 1'b1;
        #1;
        wait_cyc = -1;
        for (int c = 0; c < 64; c++) begin
            if (req_if.req_ready_o[id]) begin
                wait_cyc = c;
                break;
            end
            step();
        end
        if (wait_cyc >= 0) step();
        req_if.req_valid_i[id] = 1'b0;
    endtask

    // From the RUN cycle: idle until the CRG latency elapses, then n beats.
    task automatic drive_beats(input int lat, input int n, output logic [15:0] last_bits,
                               output logic [ID_W-1:0] id_or, output logic [ID_W-1:0] id_and,
                               output int run_cnt, output int rdy_cnt);
        logic            l;
        logic [ID_W-1:0] bid;
        last_bits = '0;
        id_or     = '0;
        id_and    = '1;
        run_cnt   = 0;
        rdy_cnt   = 0;
        for (int k = 0; k < lat - 1; k++) begin
            step();
            if (crg_run_o) run_cnt++;
            if (|req_if.req_ready_o) rdy_cnt++;
        end
        for (int k = 0; k < n; k++) begin
            beat(l, bid);
            last_bits[k] = l;
            id_or        = id_or | bid;
            id_and       = id_and & bid;
            if (crg_run_o) run_cnt++;
            if (|req_if.req_ready_o) rdy_cnt++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [63:0] obs;
        rst_n    = 1'b0;
        crg_dvld = 1'b0;
        key      = 32'hA5A5_0F0F;
        req_if.req_valid_i = '0;
        for (int i = 0; i < N_REQ; i++) req_if.req_desc_i[i] = '0;
        repeat (3) step();
        obs = 64'({busy_o, crg_run_o, done_o, err_o, beat_last_o, req_if.req_ready_o,
                   beat_id_o, resp_id_o, crg_party_o, crg_mode_o, crg_width_o,
                   crg_cnt_start_o, crg_cnt_end_o, dbg_state_o});
        n_checks++;
        if (obs !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", obs);
        end
        n_checks++;
        if (crg_key_o !== 32'hA5A5_0F0F) begin
            n_fail++;
            $display("FAIL key_passthrough: got %h expected a5a50f0f", crg_key_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_round_robin();
        logic [N_REQ-1:0] exp_gnt;
        logic [ID_W-1:0]  exp_id;
        logic [15:0]      lb;
        logic [ID_W-1:0]  ior, iand;
        int               rc, yc, got;
        exp_q = {2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < N_REQ; i++)
            req_if.req_desc_i[i] = mk_desc(1'b0, MODE_UNIFORM, 2'd1, i + 1, i + 1);
        req_if.req_valid_i = '1;
        #1;
        for (int j = 0; j < 5; j++) begin
            got = -1;
            for (int c = 0; c < 64; c++) begin
                if (|req_if.req_ready_o) begin
                    got = c;
                    break;
                end
                step();
            end
            n_checks++;
            if (got < 0) begin
                n_fail++;
                $display("FAIL rr_grant_timeout job %0d: no ready within 64 cycles", j);
                req_if.req_valid_i = '0;
                return;
            end
            exp_id           = exp_q.pop_front();
            exp_gnt          = '0;
            exp_gnt[exp_id]  = 1'b1;
            n_checks++;
            if (req_if.req_ready_o !== exp_gnt) begin
                n_fail++;
                $display("FAIL rr_grant job %0d: got %b expected %b", j, req_if.req_ready_o, exp_gnt);
            end
            step();
            if (j == 4) req_if.req_valid_i = '0;
            n_checks++;
            if ({busy_o, req_if.req_ready_o} !== {1'b1, 4'b0000}) begin
                n_fail++;
                $display("FAIL rr_busy_no_grant job %0d: got busy=%b ready=%b expected busy=1 ready=0000",
                         j, busy_o, req_if.req_ready_o);
            end
            step();
            drive_beats(CRG_LAT, 1, lb, ior, iand, rc, yc);
            n_checks++;
            if (yc !== 0) begin
                n_fail++;
                $display("FAIL rr_ready_while_busy job %0d: got %0d ready cycles expected 0", j, yc);
            end
            step();
            n_checks++;
            if ({done_o, err_o, resp_id_o} !== {1'b1, 1'b0, exp_id}) begin
                n_fail++;
                $display("FAIL rr_done job %0d: got done=%b err=%b id=%0d expected done=1 err=0 id=%0d",
                         j, done_o, err_o, resp_id_o, exp_id);
            end
            step();
        end
    endtask

    task automatic test_single_job();
        logic [15:0]     lb;
        logic [ID_W-1:0] ior, iand;
        int              rc, yc, w;
        send(0, mk_desc(1'b1, MODE_BINARY, 2'd2, 5, 8), w);
        n_checks++;
        if (w !== 0 || crg_run_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_accept: got wait=%0d run=%b expected wait=0 run=0", w, crg_run_o);
        end
        step();
        n_checks++;
        if ({crg_run_o, crg_party_o, crg_mode_o, crg_width_o, crg_cnt_start_o, crg_cnt_end_o} !==
            {1'b1, 1'b1, MODE_BINARY, 2'd2, 16'd5, 16'd8}) begin
            n_fail++;
            $display("FAIL single_run_cfg: got run=%b party=%b mode=%0d width=%0d start=%0d end=%0d expected 1 1 1 2 5 8",
                     crg_run_o, crg_party_o, crg_mode_o, crg_width_o, crg_cnt_start_o, crg_cnt_end_o);
        end
        drive_beats(CRG_LAT, 4, lb, ior, iand, rc, yc);
        n_checks++;
        if (lb[3:0] !== 4'b1000 || rc !== 0) begin
            n_fail++;
            $display("FAIL single_beats: got last=%b run_cycles=%0d expected last=1000 run_cycles=0", lb[3:0], rc);
        end
        n_checks++;
        if (ior !== 2'd0 || iand !== 2'd0) begin
            n_fail++;
            $display("FAIL single_beat_id: got or=%0d and=%0d expected 0", ior, iand);
        end
        step();
        n_checks++;
        if ({done_o, err_o, resp_id_o} !== {1'b1, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL single_done: got done=%b err=%b id=%0d expected 1 0 0", done_o, err_o, resp_id_o);
        end
        step();
        n_checks++;
        if ({busy_o, done_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL single_idle: got busy=%b done=%b expected 0 0", busy_o, done_o);
        end
    endtask

    task automatic test_invalid();
        int        w;
        int        ids [3];
        job_desc_t ds  [3];
        ids[0] = 1; ds[0] = mk_desc(1'b0, MODE_ARITH, 2'd3, 0, 5);
        ids[1] = 2; ds[1] = mk_desc(1'b0, MODE_ARITH, 2'd3, 7, 3);
        ids[2] = 3; ds[2] = mk_desc(1'b0, MODE_ARITH, 2'd3, 4, 0);
        for (int k = 0; k < 3; k++) begin
            send(ids[k], ds[k], w);
            n_checks++;
            if (w < 0 || crg_run_o !== 1'b0) begin
                n_fail++;
                $display("FAIL invalid_accept %0d: got wait=%0d run=%b expected accept run=0", k, w, crg_run_o);
            end
            step();
            n_checks++;
            if ({err_o, done_o, crg_run_o, resp_id_o} !== {1'b1, 1'b0, 1'b0, ID_W'(ids[k])}) begin
                n_fail++;
                $display("FAIL invalid_err %0d: got err=%b done=%b run=%b id=%0d expected 1 0 0 %0d",
                         k, err_o, done_o, crg_run_o, resp_id_o, ids[k]);
            end
            n_checks++;
            if ({crg_party_o, crg_mode_o, crg_width_o, crg_cnt_start_o, crg_cnt_end_o} !==
                {1'b1, MODE_BINARY, 2'd2, 16'd5, 16'd8}) begin
                n_fail++;
                $display("FAIL invalid_cfg_held %0d: got start=%0d end=%0d mode=%0d expected 5 8 1",
                         k, crg_cnt_start_o, crg_cnt_end_o, crg_mode_o);
            end
            step();
            n_checks++;
            if ({busy_o, err_o} !== 2'b00) begin
                n_fail++;
                $display("FAIL invalid_idle %0d: got busy=%b err=%b expected 0 0", k, busy_o, err_o);
            end
        end
    endtask

    task automatic test_single_beat();
        logic [15:0]     lb;
        logic [ID_W-1:0] ior, iand;
        int              rc, yc, w;
        // A stray beat while idle must not be taken as part of the next job.
        @(negedge clk);
        crg_dvld = 1'b1;
        #1;
        n_checks++;
        if ({beat_last_o, busy_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_beat_ignored: got last=%b busy=%b expected 0 0", beat_last_o, busy_o);
        end
        step();
        send(0, mk_desc(1'b0, MODE_ARITH, 2'd1, 9, 9), w);
        step();
        n_checks++;
        if ({crg_run_o, crg_cnt_start_o, crg_cnt_end_o} !== {1'b1, 16'd9, 16'd9}) begin
            n_fail++;
            $display("FAIL one_beat_cfg: got run=%b start=%0d end=%0d expected 1 9 9",
                     crg_run_o, crg_cnt_start_o, crg_cnt_end_o);
        end
        drive_beats(CRG_LAT, 1, lb, ior, iand, rc, yc);
        n_checks++;
        if (lb[0] !== 1'b1 || ior !== 2'd0) begin
            n_fail++;
            $display("FAIL one_beat_last: got last=%b id=%0d expected 1 0", lb[0], ior);
        end
        step();
        n_checks++;
        if ({done_o, err_o, resp_id_o} !== {1'b1, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL one_beat_done: got done=%b err=%b id=%0d expected 1 0 0", done_o, err_o, resp_id_o);
        end
        step();
    endtask

    task automatic test_watchdog();
        logic [15:0]     lb;
        logic [ID_W-1:0] ior, iand;
        logic            l;
        logic [ID_W-1:0] bid;
        logic [1:0]      tail;
        int              rc, yc, w, early;
        // Stall after two of four beats: error once WDOG idle cycles pass.
        send(1, mk_desc(1'b0, MODE_UNIFORM, 2'd0, 1, 4), w);
        step();
        drive_beats(CRG_LAT, 2, lb, ior, iand, rc, yc);
        early = 0;
        for (int k = 0; k < WDOG; k++) begin
            step();
            if (err_o || done_o) early++;
        end
        n_checks++;
        if (early !== 0 || busy_o !== 1'b1 || lb[1:0] !== 2'b00) begin
            n_fail++;
            $display("FAIL wdog_early: got pulses=%0d busy=%b last=%b expected 0 1 00", early, busy_o, lb[1:0]);
        end
        step();
        n_checks++;
        if ({err_o, done_o, resp_id_o} !== {1'b1, 1'b0, 2'd1}) begin
            n_fail++;
            $display("FAIL wdog_err: got err=%b done=%b id=%0d expected 1 0 1", err_o, done_o, resp_id_o);
        end
        step();
        n_checks++;
        if (dbg_state_o !== ST_IDLE) begin
            n_fail++;
            $display("FAIL wdog_idle: got state=%0d expected 0", dbg_state_o);
        end
        // Next job: a beat landing exactly on the expiry cycle keeps it alive.
        send(2, mk_desc(1'b1, MODE_ARITH, 2'd3, 10, 13), w);
        step();
        n_checks++;
        if ({crg_run_o, crg_cnt_start_o, crg_cnt_end_o} !== {1'b1, 16'd10, 16'd13}) begin
            n_fail++;
            $display("FAIL wdog_next_cfg: got run=%b start=%0d end=%0d expected 1 10 13",
                     crg_run_o, crg_cnt_start_o, crg_cnt_end_o);
        end
        drive_beats(CRG_LAT, 2, lb, ior, iand, rc, yc);
        early = 0;
        for (int k = 0; k < WDOG - 1; k++) begin
            step();
            if (err_o || done_o) early++;
        end
        tail = '0;
        for (int k = 0; k < 2; k++) begin
            beat(l, bid);
            tail[k] = l;
            if (err_o || done_o) early++;
        end
        n_checks++;
        if (early !== 0 || tail !== 2'b10 || ior !== 2'd2 || iand !== 2'd2 || bid !== 2'd2) begin
            n_fail++;
            $display("FAIL wdog_edge_beat: got pulses=%0d last=%b id=%0d/%0d/%0d expected 0 10 2/2/2",
                     early, tail, ior, iand, bid);
        end
        step();
        n_checks++;
        if ({done_o, err_o, resp_id_o} !== {1'b1, 1'b0, 2'd2}) begin
            n_fail++;
            $display("FAIL wdog_next_done: got done=%b err=%b id=%0d expected 1 0 2", done_o, err_o, resp_id_o);
        end
        step();
    endtask

    task automatic test_reset_mid_stream();
        logic [15:0]     lb;
        logic [ID_W-1:0] ior, iand;
        logic [63:0]     obs;
        int              rc, yc, w, pulses;
        // Pointer sits at 3 after this grant, so a reset pointer is visible.
        send(2, mk_desc(1'b1, MODE_BINARY, 2'd1, 1, 4), w);
        step();
        drive_beats(CRG_LAT, 2, lb, ior, iand, rc, yc);
        @(negedge clk);
        crg_dvld = 1'b1;
        rst_n    = 1'b0;
        #1;
        obs = 64'({busy_o, crg_run_o, done_o, err_o, beat_last_o, req_if.req_ready_o,
                   beat_id_o, resp_id_o, crg_party_o, crg_mode_o, crg_width_o,
                   crg_cnt_start_o, crg_cnt_end_o, dbg_state_o});
        n_checks++;
        if (obs !== 64'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %h expected 0", obs);
        end
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (done_o || err_o) pulses++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        if (done_o || err_o) pulses++;
        n_checks++;
        if (pulses !== 0 || dbg_state_o !== ST_IDLE) begin
            n_fail++;
            $display("FAIL midreset_no_resp: got pulses=%0d state=%0d expected 0 0", pulses, dbg_state_o);
        end
        req_if.req_desc_i[0]  = mk_desc(1'b0, MODE_UNIFORM, 2'd0, 1, 1);
        req_if.req_desc_i[3]  = mk_desc(1'b0, MODE_UNIFORM, 2'd0, 1, 1);
        req_if.req_valid_i[0] = 1'b1;
        req_if.req_valid_i[3] = 1'b1;
        #1;
        n_checks++;
        if (req_if.req_ready_o !== 4'b0001) begin
            n_fail++;
            $display("FAIL midreset_ptr: got ready=%b expected 0001", req_if.req_ready_o);
        end
        req_if.req_valid_i = '0;
        step();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_round_robin();
        test_single_job();
        test_invalid();
        test_single_beat();
        test_watchdog();
        test_reset_mid_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/crg_job_sched.md
Name: crg_job_sched

Overview:
- Job scheduler in front of the correlated random generator (CRG).
- Arbitrates job descriptors from N_REQ requesters and programs the CRG config/count window. Issues the single-cycle run pulse, then holds the config stable until every output beat has drained.
- Tags each CRG output beat with the owning requester ID, flags the last beat, and reports completion or error.

Parameters:
N_REQ, 4, number of requesters (2..16)
ID_W, $clog2(N_REQ), requester ID width
CRG_LAT, 28, cycles from run pulse to first CRG dvld beat
WDOG, CRG_LAT+8, max consecutive STREAM cycles with no beat before a timeout error

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
key_i  in  key_t  global key, passed through to crg_key_o
req_valid_i  in  N_REQ  descriptor valid, one per requester
req_ready_o  out  N_REQ  descriptor accept, one-hot, at most one bit high
req_desc_i  in  N_REQ x job_desc_t  {party, mode, width, cnt_start, cnt_end}
crg_key_o  out  key_t  to CRG
crg_party_o  out  1  to CRG
crg_mode_o  out  mode_t  to CRG
crg_width_o  out  width_t  to CRG
crg_cnt_start_o  out  cr_cnt_t  to CRG
crg_cnt_end_o  out  cr_cnt_t  to CRG
crg_run_o  out  1  one-cycle run pulse to CRG
crg_dvld_i  in  1  CRG output beat valid
beat_id_o  out  ID_W  owner of the current beat; valid when crg_dvld_i is high
beat_last_o  out  1  high together with crg_dvld_i on the job's final beat
done_o  out  1  one-cycle job-complete pulse
err_o  out  1  one-cycle job-error pulse
resp_id_o  out  ID_W  requester ID for done_o / err_o
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n_i low):
  - State = IDLE; round-robin pointer = 0.
  - All outputs 0; all config registers 0.
- States: IDLE, LOAD, RUN, STREAM, RESP.
- IDLE:
  - If any req_valid_i is high, grant the first valid requester at or after the pointer (round-robin). Assert its req_ready_o for exactly that cycle.
  - The handshake completes on valid&ready; latch the descriptor and the ID.
  - The pointer moves to grant+1 mod N_REQ.
  - Go to LOAD. No grant is made in any other state.
- LOAD (1 cycle): validate the descriptor.
  - Invalid if cnt_start==0, or cnt_end==0, or cnt_end<cnt_start.
  - If invalid: go to RESP with err. crg_run_o is never asserted and the config outputs are not updated.
  - If valid: drive the config outputs from the latched descriptor and load beats_left = cnt_end-cnt_start+1 (cr_cnt_t width). Go to RUN.
- RUN (1 cycle):
  - crg_run_o=1. Config outputs are already stable, having been registered one cycle earlier.
  - Clear the watchdog counter. Go to STREAM.
- STREAM:
  - Each crg_dvld_i beat decrements beats_left and clears the watchdog.
  - beat_last_o is combinational: crg_dvld_i && beats_left==1.
  - The beat on which beats_left reaches 0 sends the FSM to RESP with done.
  - A cycle with no beat increments the watchdog. When the watchdog reaches WDOG, go to RESP with err.
- RESP (1 cycle):
  - Pulse done_o or err_o, never both; resp_id_o = latched ID.
  - Go to IDLE. A new grant is possible in the next cycle.
- Config outputs hold their values from LOAD until the next valid LOAD. They must not change while the CRG pipeline is draining.
- beat_id_o equals the latched ID from LOAD onward.
- Any crg_dvld_i in IDLE/LOAD/RUN/RESP is ignored and does not affect counters.
- Single-beat job (start==end): beats_left=1; the first beat is also last.
- Simultaneous: a beat arriving on the same cycle the watchdog would expire counts as a beat, and the watchdog does not fire.
- Reset during STREAM aborts the job with no done/err pulse; the requester must resubmit.
- Arithmetic: cnt_end-cnt_start+1 cannot overflow for valid descriptors because start>=1.

Decomposition:
- TYPES package gains:
  - job_desc_t (packed struct: party, mode_t, width_t, cr_cnt_t start, cr_cnt_t end)
  - sched_state_t enum
  - CRG_LAT constant shared with CRG's latency parameter
- One sub-module: rr_arbiter (N_REQ request vector + pointer -> one-hot grant, grant index).

Test Plan:
- Single job, req 0, start=5, end=8: run pulse 2 cycles after accept; 4 beats tagged ID 0; beat_last_o on beat 4; done_o next cycle; resp_id_o=0.
- Invalid descriptors (start=0; end=3 with start=7): err_o 2 cycles after accept; crg_run_o stays 0; config outputs unchanged.
- All 4 requesters valid continuously: grants go 0,1,2,3,0; no new grant while busy_o is high; each job's done carries the matching ID.
- start=end=9: exactly one beat, with beat_last_o high on it; then done_o.
- Stall crg_dvld_i after 2 of 4 beats: err_o after WDOG idle cycles; FSM returns to IDLE; the next job runs normally.
- Assert rst_n_i low mid-STREAM: all outputs 0 immediately; no done/err; pointer=0 after release.
